// File: rtl/regfile_pkg.sv
// Shared definitions for the parameterised register file: controller state
// encoding and the default parameter values used by every file of the block.
package regfile_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } rf_state_e;

  localparam int DEF_DATA_W   = 16;
  localparam int DEF_ADDR_W   = 4;
  localparam int DEF_NUM_RD   = 2;
  localparam int DEF_ZERO_REG = 0;
  localparam int DEF_BYPASS   = 0;

endpackage

// File: rtl/regfile_if.sv
// Register-file access bus: one write port, NUM_RD packed read ports and the
// ready flag that tells the master when writes are accepted.
interface regfile_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = DEF_NUM_RD
);

  logic                     RegWrite;
  logic [ADDR_W-1:0]        write_register;
  logic [DATA_W-1:0]        write_data;
  logic [NUM_RD*ADDR_W-1:0] read_register;
  logic [NUM_RD*DATA_W-1:0] read_data;
  logic                     ready;

  modport master (
    output RegWrite,
    output write_register,
    output write_data,
    output read_register,
    input  read_data,
    input  ready
  );

  modport slave (
    input  RegWrite,
    input  write_register,
    input  write_data,
    input  read_register,
    output read_data,
    output ready
  );

endinterface

// File: rtl/regfile_init_fsm.sv
// INIT/RUN controller: after reset it walks idx over every register once,
// then parks in RUN with ready asserted until the next reset.
module regfile_init_fsm
  import regfile_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  output logic              init_active,
  output logic [ADDR_W-1:0] init_idx,
  output logic              ready
);

  rf_state_e         state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              ready_q, ready_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_INIT;
      idx_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ready_q <= ready_d;
    end
  end

  // The last INIT edge holds idx at all-ones so it can never start a second pass.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ready_d = ready_q;
    case (state_q)
      ST_INIT: begin
        if (idx_q == '1) begin
          state_d = ST_RUN;
          ready_d = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_RUN: begin
        ready_d = 1'b1;
      end
      default: begin
        state_d = ST_INIT;
        idx_d   = '0;
        ready_d = 1'b0;
      end
    endcase
  end

  assign init_active = (state_q == ST_INIT);
  assign init_idx    = idx_q;
  assign ready       = ready_q;

endmodule

// File: rtl/regfile_param.sv
// Parameterised register file: self-initialising array (rf[i] = i), one write
// port, NUM_RD combinational read ports with optional forwarding and zero register.
module regfile_param
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int ZERO_REG = DEF_ZERO_REG,
  parameter int BYPASS   = DEF_BYPASS
) (
  input  logic      clk,
  input  logic      reset,
  regfile_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0]        rf_q [DEPTH];
  logic                     init_active;
  logic [ADDR_W-1:0]        init_idx;
  logic                     ready;
  logic                     wr_en_d;
  logic [ADDR_W-1:0]        wr_addr_d;
  logic [DATA_W-1:0]        wr_data_d;
  logic                     fwd_en;
  logic [NUM_RD*DATA_W-1:0] rd_bus;

  function automatic logic [DATA_W-1:0] init_value(input logic [ADDR_W-1:0] i);
    return DATA_W'(i);
  endfunction

  function automatic logic is_zero_addr(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  regfile_init_fsm #(
    .ADDR_W (ADDR_W)
  ) u_init_fsm (
    .clk         (clk),
    .reset       (reset),
    .init_active (init_active),
    .init_idx    (init_idx),
    .ready       (ready)
  );

  assign bus.ready = ready;

  // INIT owns the write port; user writes only land once the controller is in RUN.
  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = bus.write_register;
    wr_data_d = bus.write_data;
    if (!reset) begin
      if (init_active) begin
        wr_en_d   = 1'b1;
        wr_addr_d = init_idx;
        wr_data_d = is_zero_addr(init_idx) ? '0 : init_value(init_idx);
      end else if (bus.RegWrite && !is_zero_addr(bus.write_register)) begin
        wr_en_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_d) begin
      rf_q[wr_addr_d] <= wr_data_d;
    end
  end

  assign fwd_en = (BYPASS != 0) && !init_active && bus.RegWrite;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;

    assign ra = bus.read_register[k*ADDR_W +: ADDR_W];

    // Zero register wins over forwarding so address 0 can never leak a write.
    always_comb begin
      rd = rf_q[ra];
      if (init_active) begin
        rd = '0;
      end else if (is_zero_addr(ra)) begin
        rd = '0;
      end else if (fwd_en && (ra == bus.write_register)) begin
        rd = bus.write_data;
      end
    end

    assign rd_bus[k*DATA_W +: DATA_W] = rd;
  end

  assign bus.read_data = rd_bus;

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: three configurations driven from one random stream,
// each checked every cycle against an array-based model of the register file.
module tb_regfile_param;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [4:0]  ra [4];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Config 0: defaults. Config 1: BYPASS=1, ZERO_REG=1. Config 2: 32b x 32, 4 ports, BYPASS=1.
  regfile_if #(.DATA_W(16), .ADDR_W(4), .NUM_RD(2)) if_a ();
  regfile_if #(.DATA_W(16), .ADDR_W(4), .NUM_RD(2)) if_b ();
  regfile_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(4)) if_c ();

  assign if_a.RegWrite       = we;
  assign if_a.write_register = wa[3:0];
  assign if_a.write_data     = wd[15:0];
  assign if_a.read_register  = {ra[1][3:0], ra[0][3:0]};
  assign if_b.RegWrite       = we;
  assign if_b.write_register = wa[3:0];
  assign if_b.write_data     = wd[15:0];
  assign if_b.read_register  = {ra[1][3:0], ra[0][3:0]};
  assign if_c.RegWrite       = we;
  assign if_c.write_register = wa;
  assign if_c.write_data     = wd;
  assign if_c.read_register  = {ra[3], ra[2], ra[1], ra[0]};

  regfile_param #(.DATA_W(16), .ADDR_W(4), .NUM_RD(2), .ZERO_REG(0), .BYPASS(0))
    u_a (.clk(clk), .reset(reset), .bus(if_a));
  regfile_param #(.DATA_W(16), .ADDR_W(4), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1))
    u_b (.clk(clk), .reset(reset), .bus(if_b));
  regfile_param #(.DATA_W(32), .ADDR_W(5), .NUM_RD(4), .ZERO_REG(0), .BYPASS(1))
    u_c (.clk(clk), .reset(reset), .bus(if_c));

  // ---------------- behavioural model ----------------
  logic [31:0] mem [3][32];
  bit          running [3];
  int          init_n [3];

  function automatic int depth_of(int c);    return (c == 2) ? 32 : 16; endfunction
  function automatic logic [31:0] dmask(int c); return (c == 2) ? 32'hffff_ffff : 32'h0000_ffff; endfunction
  function automatic logic [4:0] amask(int c);  return (c == 2) ? 5'h1f : 5'h0f; endfunction
  function automatic bit has_zero(int c);    return c == 1; endfunction
  function automatic bit has_byp(int c);     return c >= 1; endfunction
  function automatic int nports(int c);      return (c == 2) ? 4 : 2; endfunction

  always @(posedge clk or posedge reset) begin
    for (int c = 0; c < 3; c++) begin
      if (reset) begin
        running[c] = 1'b0;
        init_n[c]  = 0;
      end else if (!running[c]) begin
        mem[c][init_n[c]] = (has_zero(c) && init_n[c] == 0) ? 32'd0 : (32'(init_n[c]) & dmask(c));
        init_n[c]++;
        if (init_n[c] == depth_of(c)) running[c] = 1'b1;
      end else if (we) begin
        if (!(has_zero(c) && (wa & amask(c)) == 5'd0)) mem[c][wa & amask(c)] = wd & dmask(c);
      end
    end
  end

  function automatic logic [31:0] exp_rd(int c, logic [4:0] a_in);
    logic [4:0] a;
    a = a_in & amask(c);
    if (reset || !running[c]) return 32'd0;
    if (has_zero(c) && a == 5'd0) return 32'd0;
    if (has_byp(c) && we && a == (wa & amask(c))) return wd & dmask(c);
    return mem[c][a];
  endfunction

  function automatic logic [31:0] dut_rd(int c, int k);
    case (c)
      0:       return {16'd0, if_a.read_data[k*16 +: 16]};
      1:       return {16'd0, if_b.read_data[k*16 +: 16]};
      default: return if_c.read_data[k*32 +: 32];
    endcase
  endfunction

  function automatic logic dut_ready(int c);
    case (c)
      0:       return if_a.ready;
      1:       return if_b.ready;
      default: return if_c.ready;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    for (int c = 0; c < 3; c++) begin
      check($sformatf("model_ready_c%0d", c), {31'd0, dut_ready(c)}, {31'd0, running[c] & ~reset});
      for (int k = 0; k < nports(c); k++)
        check($sformatf("model_rd_c%0d_p%0d", c, k), dut_rd(c, k), exp_rd(c, ra[k]));
    end
  end

  // ---------------- stimulus ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_inputs(input bit allow_we);
    we = allow_we ? 1'($urandom_range(0, 1)) : 1'b0;
    wa = 5'($urandom);
    wd = $urandom;
    for (int k = 0; k < 4; k++)
      ra[k] = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
  endtask

  initial begin
    reset = 1'b1;
    we = 1'b0; wa = '0; wd = '0;
    for (int k = 0; k < 4; k++) ra[k] = '0;
    repeat (3) next_cycle();
    reset = 1'b0;

    // Seven INIT cycles with writes requested, then an aborting reset held two cycles.
    for (int i = 0; i < 7; i++) begin
      randomize_inputs(1'b1);
      we = 1'b1;
      next_cycle();
    end
    reset = 1'b1;
    repeat (2) next_cycle();
    reset = 1'b0;

    // Full re-INIT while hammering reg 3 with writes that must be ignored.
    for (int i = 0; i < 16; i++) begin
      we = 1'b1; wa = 5'd3; wd = $urandom; ra[0] = 5'($urandom); ra[1] = 5'd3;
      @(negedge clk);
      check("init_ready_low", {31'd0, if_a.ready}, 32'd0);
      check("init_read_zero", {16'd0, if_a.read_data[15:0]}, 32'd0);
      next_cycle();
    end
    we = 1'b0; ra[0] = 5'd3; ra[1] = 5'd10;
    @(negedge clk);
    check("a_ready_after_16", {31'd0, if_a.ready}, 32'd1);
    check("a_rf3_kept", {16'd0, if_a.read_data[15:0]}, 32'h0003);
    check("a_rf10", {16'd0, if_a.read_data[31:16]}, 32'h000a);
    check("c_still_init", {31'd0, if_c.ready}, 32'd0);

    // Finish the 32-entry INIT of config 2 (16 edges elapsed so far).
    for (int i = 0; i < 16; i++) begin
      next_cycle();
      randomize_inputs(1'b0);
    end
    for (int k = 0; k < 4; k++) ra[k] = 5'd31;
    @(negedge clk);
    check("c_ready_after_32", {31'd0, if_c.ready}, 32'd1);
    for (int k = 0; k < 4; k++)
      check($sformatf("c_rf31_p%0d", k), if_c.read_data[k*32 +: 32], 32'h0000_001f);

    // Write BEEF to reg 5 while port 0 reads it.
    next_cycle();
    we = 1'b1; wa = 5'd5; wd = 32'h0000_beef; ra[0] = 5'd5; ra[1] = 5'd5;
    @(negedge clk);
    check("a_nobyp_old", {16'd0, if_a.read_data[15:0]}, 32'h0005);
    check("b_byp_new", {16'd0, if_b.read_data[15:0]}, 32'hbeef);
    next_cycle();
    we = 1'b0;
    @(negedge clk);
    check("a_nobyp_next", {16'd0, if_a.read_data[15:0]}, 32'hbeef);

    // Write 1234 to reg 0: zero register holds 0 even with forwarding.
    next_cycle();
    we = 1'b1; wa = 5'd0; wd = 32'h0000_1234; ra[0] = 5'd0; ra[1] = 5'd0;
    @(negedge clk);
    check("b_zero_same_p0", {16'd0, if_b.read_data[15:0]}, 32'd0);
    check("b_zero_same_p1", {16'd0, if_b.read_data[31:16]}, 32'd0);
    next_cycle();
    we = 1'b0;
    @(negedge clk);
    check("b_zero_next", {16'd0, if_b.read_data[15:0]}, 32'd0);
    check("a_reg0_written", {16'd0, if_a.read_data[15:0]}, 32'h1234);

    // Random RUN traffic with one mid-run reset.
    for (int i = 0; i < 400; i++) begin
      next_cycle();
      randomize_inputs(1'b1);
      reset = (i == 200);
    end
    next_cycle();
    reset = 1'b0;
    randomize_inputs(1'b0);
    repeat (33) next_cycle();

    // RUN write of AAAA to reg 9, then reset rebuilds it to 9.
    we = 1'b1; wa = 5'd9; wd = 32'h0000_aaaa;
    next_cycle();
    we = 1'b0; ra[0] = 5'd9;
    @(negedge clk);
    check("a_rf9_written", {16'd0, if_a.read_data[15:0]}, 32'haaaa);
    next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    repeat (32) next_cycle();
    @(negedge clk);
    check("a_rf9_rebuilt", {16'd0, if_a.read_data[15:0]}, 32'h0009);
    check("c_rf9_rebuilt", if_c.read_data[31:0], 32'h0000_0009);

    next_cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_param.md
REGFILE_PARAM -- requirements
Module: regfile_param

Interface
REQ-001 Parameter DATA_W, default 16, SHALL set the register width in bits.
REQ-002 Parameter ADDR_W, default 4, SHALL set address width; DEPTH = 2**ADDR_W registers.
REQ-003 Parameter NUM_RD, default 2, SHALL set the number of independent read ports (1..8).
REQ-004 Parameter ZERO_REG, default 0, SHALL hardwire register 0 to zero when set to 1.
REQ-005 Parameter BYPASS, default 0, SHALL enable write-to-read forwarding when set to 1.
REQ-006 clk  input  1  sole clock; all state updates on rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 RegWrite  input  1  write enable, sampled on rising clk.
REQ-009 write_register  input  ADDR_W  write address.
REQ-010 write_data  input  DATA_W  write data.
REQ-011 read_register  input  NUM_RD*ADDR_W  packed read addresses; port k at bits [k*ADDR_W +: ADDR_W].
REQ-012 read_data  output  NUM_RD*DATA_W  packed read data; port k at bits [k*DATA_W +: DATA_W].
REQ-013 ready  output  1  high when initialisation is complete and writes are accepted.

Function
REQ-014 Controller SHALL have two states: INIT and RUN.
REQ-015 In INIT, each rising clk SHALL write rf[idx] = idx (zero-extended or truncated to DATA_W) and increment idx.
REQ-016 INIT SHALL move to RUN on the edge that writes idx = DEPTH-1; INIT lasts exactly DEPTH cycles after reset release.
REQ-017 ready SHALL be registered: 0 in INIT, 1 in RUN; first high after the DEPTH-th rising edge following reset deassertion.
REQ-018 In INIT, RegWrite SHALL be ignored, and every read_data port SHALL return 0.
REQ-019 In RUN, RegWrite=1 SHALL write write_data to rf[write_register] on the rising edge; there is no other write path.
REQ-020 Reads SHALL be combinational: read_data port k = rf[read_register port k], zero-latency.
REQ-021 With BYPASS=1, in RUN, RegWrite=1 and a read address equal to write_register SHALL return write_data in the same cycle.
REQ-022 With BYPASS=0, a same-cycle read of the address being written SHALL return the old value; new value visible from the next cycle.
REQ-023 With ZERO_REG=1, writes to address 0 SHALL be discarded, INIT SHALL write 0 there, and reads of address 0 SHALL return 0 even when bypass matches.
REQ-024 All NUM_RD ports SHALL be independent; identical addresses on several ports SHALL return identical data.
REQ-025 The idx counter SHALL be ADDR_W bits and SHALL not wrap into a second INIT pass.

Reset
REQ-026 Asserting reset SHALL asynchronously force state=INIT, idx=0, ready=0.
REQ-027 The register array SHALL not be reset; contents are rebuilt by INIT after release.
REQ-028 Reset asserted mid-INIT or mid-RUN SHALL abort the current activity; a RUN write on the same edge as reset assertion SHALL be lost.
REQ-029 After any reset release, behaviour SHALL be identical to power-up: full INIT of DEPTH cycles, then RUN.

Structure
REQ-030 Shared package regfile_pkg SHALL hold the INIT/RUN state encoding and the default parameter constants.
REQ-031 The INIT/RUN controller (state, idx, ready) SHALL be one sub-module, regfile_init_fsm; the array, write logic, and read/bypass muxes stay in regfile_param.
REQ-032 Read ports SHALL be built with a generate loop over NUM_RD.

Verification
REQ-033 Defaults; release reset, read every address during INIT -> read_data=0, ready=0 for 16 cycles; after 16th edge ready=1 and rf[i]=i (rf[10]=16'h000a).
REQ-034 RUN, write 16'hBEEF to reg 5 with port0 reading 5: BYPASS=0 -> 16'h0005 that cycle, 16'hBEEF next; BYPASS=1 -> 16'hBEEF same cycle.
REQ-035 ZERO_REG=1: write 16'h1234 to reg 0 -> every read of address 0 returns 0, including same cycle with BYPASS=1.
REQ-036 Assert reset 7 cycles into INIT, hold 2 cycles, release -> ready low a full 16 cycles more; RegWrite during INIT leaves rf[3]=16'h0003.
REQ-037 DATA_W=32, ADDR_W=5, NUM_RD=4: INIT lasts 32 cycles; all four ports read 31 simultaneously -> 32'h0000001F on each.
REQ-038 RUN, write 16'hAAAA to reg 9, then assert reset -> after re-INIT, reg 9 reads 16'h0009.
